// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the MEM stage: access-size encodings, byte-enable
//   constants, the MEM stage state type and an alignment helper.
package mips_pkg;

    localparam logic MEM_WORD = 1'b0;
    localparam logic MEM_BYTE = 1'b1;

    localparam logic [3:0] BE_NONE  = 4'h0;
    localparam logic [3:0] BE_WORD  = 4'hF;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_t;

    // Byte accesses are always aligned; word accesses need addr[1:0] == 0.
    function automatic logic access_aligned(input logic mtype, input logic [1:0] addr_lo);
        return (mtype == MEM_BYTE) || (addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
//   Combinational byte-lane steering for the MEM stage.
//   Store side: byte-enables and write data (byte replicated to all lanes).
//   Load side : lane extraction and zero/sign extension of byte loads.
// Ports
//   st_type     in  1   access size of the store being launched (MEM_WORD/MEM_BYTE)
//   st_addr_lo  in  2   low address bits of the store
//   st_data     in  32  raw store data
//   st_be       out 4   byte-enables for the store
//   st_wdata    out 32  data as driven onto the memory port
//   ld_type     in  1   access size of the outstanding load
//   ld_addr_lo  in  2   latched low address bits of the load
//   ld_rdata    in  32  raw data returned by memory
//   ld_data     out 32  lane-extracted, extended load data
module mem_lane_align
    import mips_pkg::*;
#(
    parameter bit BYTE_SIGN_EXT = 1'b0
)(
    input  logic        st_type,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic        ld_type,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0] ld_byte;

    always_comb begin
        st_be    = BE_WORD;
        st_wdata = st_data;
        if (st_type == MEM_BYTE) begin
            st_be    = BE_BYTE0 << st_addr_lo;
            st_wdata = {4{st_data[7:0]}};
        end
    end

    always_comb begin
        ld_byte = ld_rdata[7:0];
        case (ld_addr_lo)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase

        ld_data = ld_rdata;
        if (ld_type == MEM_BYTE) begin
            ld_data = BYTE_SIGN_EXT ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   Pipeline MEM stage. Takes the EX/MEM register outputs, performs at most one
//   load/store per instruction over a req/ack data-memory port, and produces
//   the MEM/WB register, a registered branch-resolve pulse and forward probes.
// Ports
//   clk, reset                        clock, synchronous active-high reset
//   we, flush                         stage enable / squash of the presented instruction
//   is_branch, pc_branch, alu_zero    branch resolve inputs
//   mem_read, mem_write, mem_type     memory operation controls
//   mem_to_reg, reg_write, reg_addr   write-back controls
//   alu_out, data_t_in                address/ALU result and store data
//   mem_req/wr/addr/wdata/be          data-memory request (registered)
//   mem_rdata, mem_ack                data-memory response
//   stall                             holds upstream while an access is pending
//   branch_taken, pc_branch_out       registered branch resolve
//   bus_err                           1-cycle pulse: timeout or misaligned word access
//   mem_to_reg_out ... mem_data       MEM/WB register
//   reg_probe, data_probe, write_probe forwarding view of the MEM/WB register
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned MAX_WAIT      = 255,
    parameter bit          BYTE_SIGN_EXT = 1'b0
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        flush,
    input  logic        is_branch,
    input  logic [31:0] pc_branch,
    input  logic        alu_zero,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_type,
    input  logic        mem_to_reg,
    input  logic [31:0] alu_out,
    input  logic [31:0] data_t_in,
    input  logic [4:0]  reg_addr,
    input  logic        reg_write,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        branch_taken,
    output logic [31:0] pc_branch_out,
    output logic        bus_err,
    output logic        mem_to_reg_out,
    output logic        reg_write_out,
    output logic [4:0]  reg_addr_out,
    output logic [31:0] alu_result,
    output logic [31:0] mem_data,
    output logic [4:0]  reg_probe,
    output logic [31:0] data_probe,
    output logic        write_probe
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    mem_state_t  state, state_nxt;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_inc;

    // Write-back fields of the instruction whose access is outstanding.
    logic        pend_load;
    logic        pend_type;
    logic [1:0]  pend_addr_lo;
    logic        pend_mem_to_reg;
    logic        pend_reg_write;
    logic [4:0]  pend_reg_addr;
    logic [31:0] pend_alu;

    logic        is_mem;
    logic        is_store;
    logic        aligned;
    logic        accept;
    logic        launch;
    logic        misaligned;
    logic        timeout;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    // A read+write request is treated as a load, so only a pure write stores.
    assign is_mem     = mem_read | mem_write;
    assign is_store   = mem_write & ~mem_read;
    assign aligned    = access_aligned(mem_type, alu_out[1:0]);
    assign accept     = (state == ST_IDLE) & we & ~flush;
    assign launch     = accept & is_mem & aligned;
    assign misaligned = accept & is_mem & ~aligned;

    // Timeout fires on the ACCESS cycle whose increment makes wait_cnt reach
    // MAX_WAIT, so mem_req is high for exactly MAX_WAIT cycles when unacked.
    assign wait_inc = wait_cnt + 8'd1;
    assign timeout  = (state == ST_ACCESS) & ~mem_ack & (wait_inc == WAIT_LIMIT);

    assign stall = (state == ST_ACCESS) | launch;

    assign reg_probe   = reg_addr_out;
    assign write_probe = reg_write_out;
    assign data_probe  = mem_to_reg_out ? mem_data : alu_result;

    mem_lane_align #(
        .BYTE_SIGN_EXT (BYTE_SIGN_EXT)
    ) u_lane_align (
        .st_type    (mem_type),
        .st_addr_lo (alu_out[1:0]),
        .st_data    (data_t_in),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .ld_type    (pend_type),
        .ld_addr_lo (pend_addr_lo),
        .ld_rdata   (mem_rdata),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (launch) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ack || timeout) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pulse-type outputs and reg_write_out default low every cycle so that a
    // cycle without a completion reads as a bubble downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt        <= 8'd0;
            mem_req         <= 1'b0;
            mem_wr          <= 1'b0;
            mem_addr        <= 32'd0;
            mem_wdata       <= 32'd0;
            mem_be          <= BE_NONE;
            branch_taken    <= 1'b0;
            pc_branch_out   <= 32'd0;
            bus_err         <= 1'b0;
            mem_to_reg_out  <= 1'b0;
            reg_write_out   <= 1'b0;
            reg_addr_out    <= 5'd0;
            alu_result      <= 32'd0;
            mem_data        <= 32'd0;
            pend_load       <= 1'b0;
            pend_type       <= MEM_WORD;
            pend_addr_lo    <= 2'b00;
            pend_mem_to_reg <= 1'b0;
            pend_reg_write  <= 1'b0;
            pend_reg_addr   <= 5'd0;
            pend_alu        <= 32'd0;
        end else begin
            branch_taken  <= 1'b0;
            bus_err       <= 1'b0;
            reg_write_out <= 1'b0;

            if (accept && is_branch && alu_zero) begin
                branch_taken  <= 1'b1;
                pc_branch_out <= pc_branch;
            end

            if (accept && !is_mem) begin
                mem_to_reg_out <= mem_to_reg;
                reg_write_out  <= reg_write;
                reg_addr_out   <= reg_addr;
                alu_result     <= alu_out;
            end

            if (misaligned) begin
                bus_err <= 1'b1;
            end

            if (launch) begin
                mem_req         <= 1'b1;
                mem_wr          <= is_store;
                mem_addr        <= {alu_out[31:2], 2'b00};
                mem_wdata       <= st_wdata;
                mem_be          <= is_store ? st_be : BE_NONE;
                wait_cnt        <= 8'd0;
                pend_load       <= mem_read;
                pend_type       <= mem_type;
                pend_addr_lo    <= alu_out[1:0];
                pend_mem_to_reg <= mem_to_reg;
                pend_reg_write  <= reg_write;
                pend_reg_addr   <= reg_addr;
                pend_alu        <= alu_out;
            end

            if (state == ST_ACCESS) begin
                wait_cnt <= wait_inc;
                if (mem_ack) begin
                    mem_req        <= 1'b0;
                    mem_wr         <= 1'b0;
                    mem_be         <= BE_NONE;
                    mem_to_reg_out <= pend_mem_to_reg;
                    reg_write_out  <= pend_reg_write;
                    reg_addr_out   <= pend_reg_addr;
                    alu_result     <= pend_alu;
                    mem_data       <= pend_load ? ld_data : 32'd0;
                end else if (timeout) begin
                    mem_req <= 1'b0;
                    mem_wr  <= 1'b0;
                    mem_be  <= BE_NONE;
                    bus_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
//   Self-checking bench for mem_stage. Two instances share all inputs: dut uses
//   zero-extended byte loads, dut_s sign-extended; both use MAX_WAIT=4.
//   Expected write-backs are queued when an instruction is driven and popped
//   by a monitor whenever dut signals a write-back.
module tb_mem_stage;
    import mips_pkg::*;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0, flush = 1'b0, is_branch = 1'b0, alu_zero = 1'b0;
    logic [31:0] pc_branch = 32'd0;
    logic        mem_read = 1'b0, mem_write = 1'b0, mem_type = 1'b0, mem_to_reg = 1'b0;
    logic [31:0] alu_out = 32'd0, data_t_in = 32'd0, mem_rdata = 32'd0;
    logic [4:0]  reg_addr = 5'd0;
    logic        reg_write = 1'b0, mem_ack = 1'b0;

    logic        mem_req, mem_wr, stall, branch_taken, bus_err;
    logic [31:0] mem_addr, mem_wdata, pc_branch_out, alu_result, mem_data, data_probe;
    logic [3:0]  mem_be;
    logic        mem_to_reg_out, reg_write_out, write_probe;
    logic [4:0]  reg_addr_out, reg_probe;

    logic        mem_req_s, mem_wr_s, stall_s, branch_taken_s, bus_err_s;
    logic [31:0] mem_addr_s, mem_wdata_s, pc_branch_out_s, alu_result_s, mem_data_s, data_probe_s;
    logic [3:0]  mem_be_s;
    logic        mem_to_reg_out_s, reg_write_out_s, write_probe_s;
    logic [4:0]  reg_addr_out_s, reg_probe_s;

    int  checks = 0;
    int  errors = 0;
    wb_t expq[$];

    always #5 clk = ~clk;

    mem_stage #(.MAX_WAIT(4), .BYTE_SIGN_EXT(1'b0)) dut (
        .clk(clk), .reset(reset), .we(we), .flush(flush), .is_branch(is_branch),
        .pc_branch(pc_branch), .alu_zero(alu_zero), .mem_read(mem_read), .mem_write(mem_write),
        .mem_type(mem_type), .mem_to_reg(mem_to_reg), .alu_out(alu_out), .data_t_in(data_t_in),
        .reg_addr(reg_addr), .reg_write(reg_write), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .stall(stall), .branch_taken(branch_taken), .pc_branch_out(pc_branch_out),
        .bus_err(bus_err), .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
        .reg_addr_out(reg_addr_out), .alu_result(alu_result), .mem_data(mem_data),
        .reg_probe(reg_probe), .data_probe(data_probe), .write_probe(write_probe)
    );

    mem_stage #(.MAX_WAIT(4), .BYTE_SIGN_EXT(1'b1)) dut_s (
        .clk(clk), .reset(reset), .we(we), .flush(flush), .is_branch(is_branch),
        .pc_branch(pc_branch), .alu_zero(alu_zero), .mem_read(mem_read), .mem_write(mem_write),
        .mem_type(mem_type), .mem_to_reg(mem_to_reg), .alu_out(alu_out), .data_t_in(data_t_in),
        .reg_addr(reg_addr), .reg_write(reg_write), .mem_req(mem_req_s), .mem_wr(mem_wr_s),
        .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .mem_be(mem_be_s), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .stall(stall_s), .branch_taken(branch_taken_s), .pc_branch_out(pc_branch_out_s),
        .bus_err(bus_err_s), .mem_to_reg_out(mem_to_reg_out_s), .reg_write_out(reg_write_out_s),
        .reg_addr_out(reg_addr_out_s), .alu_result(alu_result_s), .mem_data(mem_data_s),
        .reg_probe(reg_probe_s), .data_probe(data_probe_s), .write_probe(write_probe_s)
    );

    // Scoreboard: every write-back from dut must match the oldest queued entry.
    always @(negedge clk) begin : sb_monitor
        wb_t e;
        if (reg_write_out === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("[TB] FAIL wb_unexpected: got rd=%0d data=%h, required no write-back", reg_probe, data_probe);
            end else begin
                e = expq.pop_front();
                if (reg_probe !== e.rd || data_probe !== e.data) begin
                    errors++;
                    $display("[TB] FAIL wb_data: got rd=%0d data=%h, required rd=%0d data=%h",
                             reg_probe, data_probe, e.rd, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic bubble();
        we = 1'b0; flush = 1'b0; is_branch = 1'b0; alu_zero = 1'b0; pc_branch = 32'd0;
        mem_read = 1'b0; mem_write = 1'b0; mem_type = MEM_WORD; mem_to_reg = 1'b0;
        alu_out = 32'd0; data_t_in = 32'd0; reg_addr = 5'd0; reg_write = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bubble();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({mem_req, mem_wr, stall, reg_write_out, bus_err, branch_taken} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b, required 000000",
                     {mem_req, mem_wr, stall, reg_write_out, bus_err, branch_taken});
        end
        checks++;
        if ({alu_result, mem_data, mem_addr, pc_branch_out} !== 128'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h %h %h %h, required all zero",
                     alu_result, mem_data, mem_addr, pc_branch_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_alu_op();
        @(negedge clk);
        we = 1'b1; alu_out = 32'h1234; reg_addr = 5'd5; reg_write = 1'b1;
        expq.push_back('{rd: 5'd5, data: 32'h1234});
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("[TB] FAIL alu_stall: got %b, required 0", stall); end
        @(negedge clk);
        bubble();
        #1;
        checks++;
        if (alu_result !== 32'h1234 || write_probe !== 1'b1 || reg_probe !== 5'd5) begin
            errors++;
            $display("[TB] FAIL alu_wb: got alu=%h wp=%b rd=%0d, required 1234 1 5", alu_result, write_probe, reg_probe);
        end
        @(negedge clk);
        checks++;
        if (write_probe !== 1'b0) begin errors++; $display("[TB] FAIL alu_bubble: got %b, required 0", write_probe); end
    endtask

    task automatic test_load_word();
        int stall_cycles = 0;
        @(negedge clk);
        we = 1'b1; mem_read = 1'b1; mem_type = MEM_WORD; alu_out = 32'h100;
        mem_to_reg = 1'b1; reg_write = 1'b1; reg_addr = 5'd7;
        expq.push_back('{rd: 5'd7, data: 32'hDEADBEEF});
        #1;
        if (stall === 1'b1) stall_cycles++;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_be !== 4'h0 || mem_addr !== 32'h100) begin
                    errors++;
                    $display("[TB] FAIL lw_req: got req=%b wr=%b be=%h addr=%h, required 1 0 0 00000100",
                             mem_req, mem_wr, mem_be, mem_addr);
                end
            end
            if (k == 3) begin
                mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
            end
            #1;
            if (stall === 1'b1) stall_cycles++;
        end
        @(negedge clk);
        bubble();
        #1;
        checks++;
        if (stall_cycles != 4) begin errors++; $display("[TB] FAIL lw_stall_len: got %0d, required 4", stall_cycles); end
        checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0 || mem_data !== 32'hDEADBEEF || reg_write_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lw_wb: got stall=%b req=%b data=%h wr=%b, required 0 0 deadbeef 1",
                     stall, mem_req, mem_data, reg_write_out);
        end
        @(negedge clk);
        checks++;
        if (reg_write_out !== 1'b0) begin errors++; $display("[TB] FAIL lw_wb_pulse: got %b, required 0", reg_write_out); end
    endtask

    task automatic test_byte_ops();
        @(negedge clk);
        we = 1'b1; mem_write = 1'b1; mem_type = MEM_BYTE; alu_out = 32'h203; data_t_in = 32'hAB;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("[TB] FAIL sb_stall: got %b, required 1", stall); end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_be !== 4'b1000 || mem_wdata !== 32'hABABABAB || mem_addr !== 32'h200) begin
            errors++;
            $display("[TB] FAIL sb_req: got req=%b wr=%b be=%b wdata=%h addr=%h, required 1 1 1000 abababab 00000200",
                     mem_req, mem_wr, mem_be, mem_wdata, mem_addr);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        bubble();
        #1;
        checks++;
        if (mem_req !== 1'b0 || reg_write_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sb_done: got req=%b wr=%b, required 0 0", mem_req, reg_write_out);
        end
        @(negedge clk);
        we = 1'b1; mem_read = 1'b1; mem_type = MEM_BYTE; alu_out = 32'h203;
        mem_to_reg = 1'b1; reg_write = 1'b1; reg_addr = 5'd9;
        expq.push_back('{rd: 5'd9, data: 32'h00000080});
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_be !== 4'h0) begin
            errors++;
            $display("[TB] FAIL lb_req: got req=%b be=%h, required 1 0", mem_req, mem_be);
        end
        mem_ack = 1'b1; mem_rdata = 32'h80000000;
        @(negedge clk);
        bubble();
        #1;
        checks++;
        if (mem_data !== 32'h00000080) begin errors++; $display("[TB] FAIL lb_zext: got %h, required 00000080", mem_data); end
        checks++;
        if (mem_data_s !== 32'hFFFFFF80 || data_probe_s !== 32'hFFFFFF80) begin
            errors++;
            $display("[TB] FAIL lb_sext: got %h/%h, required ffffff80", mem_data_s, data_probe_s);
        end
    endtask

    task automatic test_store_word();
        @(negedge clk);
        we = 1'b1; mem_write = 1'b1; mem_type = MEM_WORD; alu_out = 32'h10; data_t_in = 32'h11223344;
        @(negedge clk);
        checks++;
        if (mem_be !== 4'hF || mem_wdata !== 32'h11223344 || mem_wr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sw_req: got be=%h wdata=%h wr=%b, required f 11223344 1", mem_be, mem_wdata, mem_wr);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        bubble();
    endtask

    task automatic test_timeout();
        int  req_cycles = 0;
        bit  dropped = 1'b0;
        @(negedge clk);
        we = 1'b1; mem_read = 1'b1; mem_type = MEM_WORD; alu_out = 32'h300;
        mem_to_reg = 1'b1; reg_write = 1'b1; reg_addr = 5'd3;
        for (int k = 0; k < 10 && !dropped; k++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                req_cycles++;
            end else begin
                dropped = 1'b1;
                bubble();
                #1;
                checks++;
                if (bus_err !== 1'b1 || reg_write_out !== 1'b0 || stall !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL to_drop: got err=%b wr=%b stall=%b, required 1 0 0", bus_err, reg_write_out, stall);
                end
            end
        end
        checks++;
        if (!dropped || req_cycles != 4) begin
            errors++;
            $display("[TB] FAIL to_len: got %0d req cycles (dropped=%b), required 4", req_cycles, dropped);
        end
        bubble();
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL to_pulse: got %b, required 0", bus_err); end
    endtask

    task automatic test_branch();
        @(negedge clk);
        we = 1'b1; is_branch = 1'b1; alu_zero = 1'b1; pc_branch = 32'h40;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("[TB] FAIL br_stall: got %b, required 0", stall); end
        @(negedge clk);
        bubble();
        checks++;
        if (branch_taken !== 1'b1 || pc_branch_out !== 32'h40) begin
            errors++;
            $display("[TB] FAIL br_taken: got %b pc=%h, required 1 00000040", branch_taken, pc_branch_out);
        end
        @(negedge clk);
        checks++;
        if (branch_taken !== 1'b0) begin errors++; $display("[TB] FAIL br_pulse: got %b, required 0", branch_taken); end
        we = 1'b1; is_branch = 1'b1; alu_zero = 1'b1; pc_branch = 32'h80; flush = 1'b1;
        @(negedge clk);
        bubble();
        checks++;
        if (branch_taken !== 1'b0) begin errors++; $display("[TB] FAIL br_flush: got %b, required 0", branch_taken); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        we = 1'b1; alu_out = 32'h11; reg_addr = 5'd1; reg_write = 1'b1;
        expq.push_back('{rd: 5'd1, data: 32'h11});
        @(negedge clk);
        alu_out = 32'h22; reg_addr = 5'd2;
        expq.push_back('{rd: 5'd2, data: 32'h22});
        @(negedge clk);
        alu_out = 32'h33; reg_addr = 5'd3; flush = 1'b1;
        #1;
        checks++;
        if (alu_result !== 32'h22) begin errors++; $display("[TB] FAIL b2b_second: got %h, required 00000022", alu_result); end
        @(negedge clk);
        bubble();
        checks++;
        if (write_probe !== 1'b0 || alu_result !== 32'h22) begin
            errors++;
            $display("[TB] FAIL b2b_flush: got wp=%b alu=%h, required 0 00000022", write_probe, alu_result);
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        we = 1'b1; mem_read = 1'b1; mem_type = MEM_WORD; alu_out = 32'h400;
        mem_to_reg = 1'b1; reg_write = 1'b1; reg_addr = 5'd4;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_req: got %b, required 1", mem_req); end
        mem_ack = 1'b1; mem_rdata = 32'h12345678; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bubble();
        #1;
        checks++;
        if ({mem_req, reg_write_out, stall, bus_err, mem_be} !== 8'd0 ||
            {alu_result, mem_data, mem_addr} !== 96'd0 || reg_addr_out !== 5'd0) begin
            errors++;
            $display("[TB] FAIL rst_mid_clear: got req=%b wr=%b stall=%b alu=%h data=%h addr=%h rd=%0d, required all zero",
                     mem_req, reg_write_out, stall, alu_result, mem_data, mem_addr, reg_addr_out);
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        we = 1'b1; mem_read = 1'b1; mem_type = MEM_WORD; alu_out = 32'h102;
        mem_to_reg = 1'b1; reg_write = 1'b1; reg_addr = 5'd6;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("[TB] FAIL mis_stall: got %b, required 0", stall); end
        @(negedge clk);
        bubble();
        checks++;
        if (mem_req !== 1'b0 || bus_err !== 1'b1 || reg_write_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mis_err: got req=%b err=%b wr=%b, required 0 1 0", mem_req, bus_err, reg_write_out);
        end
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mis_pulse: got err=%b req=%b, required 0 0", bus_err, mem_req);
        end
    endtask

    initial begin
        $display("[TB] starting mem_stage bench");
        test_reset();
        test_alu_op();
        test_load_word();
        test_byte_ops();
        test_store_word();
        test_timeout();
        test_branch();
        test_back_to_back();
        test_reset_mid_access();
        test_misaligned();
        repeat (3) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL wb_missing: got %0d write-backs outstanding, required 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
